// File: rtl/reg_file_pkg.sv
// reg_file_param shared types.
// Clear-sweep state encoding used by the sequencer.
package reg_file_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/reg_file_if.sv
// Decode/writeback side bundle of the register file.
// master drives addresses and data; slave is the register file.
interface reg_file_if #(
    parameter int W     = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          we;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] raddrA;
    logic [AW-1:0] raddrB;
    logic          use_imm;
    logic [W-1:0]  imm;
    logic          set_pend;
    logic [AW-1:0] pend_addr;
    logic          clear_req;
    logic [W-1:0]  data_outA;
    logic [W-1:0]  data_outB;
    logic          busyA;
    logic          busyB;
    logic          ready;

    modport master (
        output we, waddr, wdata, raddrA, raddrB,
        output use_imm, imm, set_pend, pend_addr, clear_req,
        input  data_outA, data_outB, busyA, busyB, ready
    );

    modport slave (
        input  we, waddr, wdata, raddrA, raddrB,
        input  use_imm, imm, set_pend, pend_addr, clear_req,
        output data_outA, data_outB, busyA, busyB, ready
    );

endinterface

// File: rtl/reg_file_clear_seq.sv
// Clear-sweep sequencer: walks every register index once,
// then parks in RUN until a clear request arrives.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     clear_req,
    output logic                     clr_en,
    output logic [$clog2(DEPTH)-1:0] clr_idx,
    output logic                     ready
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t     state;
    logic [AW-1:0] idx;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= RF_CLEAR;
            idx   <= '0;
            ready <= 1'b0;
        end else begin
            unique case (state)
                RF_CLEAR: begin
                    idx <= idx + AW'(1);
                    // compared before the increment wraps
                    if (idx == LAST) begin
                        state <= RF_RUN;
                        ready <= 1'b1;
                    end
                end
                RF_RUN: begin
                    if (clear_req) begin
                        state <= RF_CLEAR;
                        idx   <= '0;
                        ready <= 1'b0;
                    end
                end
                default: begin
                    state <= RF_CLEAR;
                    idx   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en  = (state == RF_CLEAR);
    assign clr_idx = idx;

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file with write bypass, pending
// scoreboard, optional zero register and clear sweep.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int W        = 8,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 0
) (
    input logic      CLK,
    input logic      reset,
    reg_file_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     regs [DEPTH];
    logic [DEPTH-1:0] pend;

    logic          clr_en;
    logic [AW-1:0] clr_idx;
    logic          run;

    reg_file_clear_seq #(
        .DEPTH(DEPTH)
    ) u_clr (
        .CLK      (CLK),
        .reset    (reset),
        .clear_req(bus.clear_req),
        .clr_en   (clr_en),
        .clr_idx  (clr_idx),
        .ready    (bus.ready)
    );

    assign run = ~clr_en;

    logic wz, pz, za, zb;
    logic upd, wr_ok, pd_ok;
    logic byp_a, byp_b;

    assign wz = (ZERO_REG != 0) && (bus.waddr == '0);
    assign pz = (ZERO_REG != 0) && (bus.pend_addr == '0);
    assign za = (ZERO_REG != 0) && (bus.raddrA == '0);
    assign zb = (ZERO_REG != 0) && (bus.raddrB == '0);

    // a clear request edge performs no update at all
    assign upd   = run & ~reset & ~bus.clear_req;
    assign wr_ok = upd & bus.we & ~wz;
    assign pd_ok = upd & bus.set_pend & ~pz;

    always_ff @(posedge CLK) begin
        if (clr_en) begin
            regs[clr_idx] <= '0;
            pend[clr_idx] <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[bus.waddr] <= bus.wdata;
                pend[bus.waddr] <= 1'b0;
            end
            // a new producer overrides the completing write
            if (pd_ok) begin
                pend[bus.pend_addr] <= 1'b1;
            end
        end
    end

    assign byp_a = wr_ok && (bus.waddr == bus.raddrA);
    assign byp_b = wr_ok && (bus.waddr == bus.raddrB);

    always_comb begin
        bus.data_outA = '0;
        bus.busyA     = 1'b0;
        if (run) begin
            if (byp_a) begin
                bus.data_outA = bus.wdata;
            end else if (!za) begin
                bus.data_outA = regs[bus.raddrA];
                bus.busyA     = pend[bus.raddrA];
            end
        end
    end

    always_comb begin
        bus.data_outB = '0;
        bus.busyB     = 1'b0;
        if (run) begin
            if (bus.use_imm) begin
                bus.data_outB = bus.imm;
            end else if (byp_b) begin
                bus.data_outB = bus.wdata;
            end else if (!zb) begin
                bus.data_outB = regs[bus.raddrB];
                bus.busyB     = pend[bus.raddrB];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: directed table, sweep timing,
// and random traffic against a reference model.
module tb_reg_file_param;
    localparam int W = 8;
    localparam int DEPTH = 16;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    reg_file_if #(.W(W), .DEPTH(DEPTH)) i0 ();
    reg_file_if #(.W(W), .DEPTH(DEPTH)) iz ();

    assign iz.we        = i0.we;
    assign iz.waddr     = i0.waddr;
    assign iz.wdata     = i0.wdata;
    assign iz.raddrA    = i0.raddrA;
    assign iz.raddrB    = i0.raddrB;
    assign iz.use_imm   = i0.use_imm;
    assign iz.imm       = i0.imm;
    assign iz.set_pend  = i0.set_pend;
    assign iz.pend_addr = i0.pend_addr;
    assign iz.clear_req = i0.clear_req;

    reg_file_param #(.W(W), .DEPTH(DEPTH), .ZERO_REG(0)) dut0 (
        .CLK(CLK), .reset(reset), .bus(i0.slave)
    );
    reg_file_param #(.W(W), .DEPTH(DEPTH), .ZERO_REG(1)) dutz (
        .CLK(CLK), .reset(reset), .bus(iz.slave)
    );

    int n_tests = 0;
    int n_fail = 0;

    // reference model: index 0 plain, index 1 zero-register
    logic [7:0] m_reg [2][16];
    logic       m_pend[2][16];
    bit         m_run = 1'b0;
    int         m_idx = 0;

    function automatic void chk(string nm, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic bit wr_taken(int k);
        return m_run && i0.we === 1'b1 && i0.clear_req !== 1'b1 && reset !== 1'b1
               && !(k == 1 && i0.waddr == 4'd0);
    endfunction

    function automatic void mread(int k, logic [3:0] a, logic im, logic [7:0] iv,
                                  output logic [7:0] d, output logic b);
        d = 8'h00;
        b = 1'b0;
        if (!m_run) return;
        if (im) d = iv;
        else if (wr_taken(k) && i0.waddr == a) d = i0.wdata;
        else if (k == 1 && a == 4'd0) d = 8'h00;
        else begin
            d = m_reg[k][a];
            b = m_pend[k][a];
        end
    endfunction

    task automatic check_model();
        logic [7:0] d;
        logic b;
        mread(0, i0.raddrA, 1'b0, 8'h00, d, b);
        chk("m0_a", i0.data_outA, d);
        chk("m0_busyA", {7'd0, i0.busyA}, {7'd0, b});
        mread(0, i0.raddrB, i0.use_imm, i0.imm, d, b);
        chk("m0_b", i0.data_outB, d);
        chk("m0_busyB", {7'd0, i0.busyB}, {7'd0, b});
        mread(1, i0.raddrA, 1'b0, 8'h00, d, b);
        chk("mz_a", iz.data_outA, d);
        chk("mz_busyA", {7'd0, iz.busyA}, {7'd0, b});
        mread(1, i0.raddrB, i0.use_imm, i0.imm, d, b);
        chk("mz_b", iz.data_outB, d);
        chk("mz_busyB", {7'd0, iz.busyB}, {7'd0, b});
        chk("m0_ready", {7'd0, i0.ready}, {7'd0, m_run});
        chk("mz_ready", {7'd0, iz.ready}, {7'd0, m_run});
    endtask

    task automatic model_edge();
        if (reset) begin
            m_run = 1'b0;
            m_idx = 0;
        end else if (!m_run) begin
            for (int k = 0; k < 2; k++) begin
                m_reg[k][m_idx]  = 8'h00;
                m_pend[k][m_idx] = 1'b0;
            end
            if (m_idx == DEPTH - 1) m_run = 1'b1;
            m_idx = (m_idx + 1) % DEPTH;
        end else if (i0.clear_req) begin
            m_run = 1'b0;
            m_idx = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (i0.we && !(k == 1 && i0.waddr == 4'd0)) begin
                    m_reg[k][i0.waddr]  = i0.wdata;
                    m_pend[k][i0.waddr] = 1'b0;
                end
                if (i0.set_pend && !(k == 1 && i0.pend_addr == 4'd0))
                    m_pend[k][i0.pend_addr] = 1'b1;
            end
        end
    endtask

    task automatic step_pre();
        @(negedge CLK);
        if (reset === 1'b0) check_model();
    endtask

    task automatic step_post();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic step();
        step_pre();
        step_post();
    endtask

    task automatic idle();
        i0.we = 0; i0.waddr = 0; i0.wdata = 0;
        i0.raddrA = 0; i0.raddrB = 0; i0.use_imm = 0; i0.imm = 0;
        i0.set_pend = 0; i0.pend_addr = 0; i0.clear_req = 0;
    endtask

    task automatic rand_in(bit allow_clr);
        i0.we        = 1'($urandom_range(0, 1));
        i0.waddr     = 4'($urandom_range(0, 15));
        i0.wdata     = 8'($urandom_range(0, 255));
        i0.raddrA    = 4'($urandom_range(0, 15));
        i0.raddrB    = 4'($urandom_range(0, 15));
        i0.use_imm   = ($urandom_range(0, 3) == 0);
        i0.imm       = 8'($urandom_range(0, 255));
        i0.set_pend  = ($urandom_range(0, 3) == 0);
        i0.pend_addr = 4'($urandom_range(0, 15));
        i0.clear_req = allow_clr && ($urandom_range(0, 63) == 0);
    endtask

    task automatic sweep_count(string nm);
        for (int e = 1; e <= DEPTH; e++) begin
            rand_in(1'b1);
            step();
            chk(nm, {7'd0, i0.ready}, {7'd0, (e == DEPTH)});
        end
    endtask

    typedef struct {
        logic we; logic [3:0] wa; logic [7:0] wd;
        logic [3:0] ra; logic [3:0] rb; logic ui; logic [7:0] iv;
        logic sp; logic [3:0] pa;
        logic [7:0] ea; logic [7:0] eb; logic ba; logic bb;
        logic [7:0] eaz; logic baz;
    } vec_t;

    vec_t tv[12];

    initial begin
        tv[0]  = '{1, 5, 8'hA7, 5, 0, 0, 8'h00, 0, 0, 8'hA7, 8'h00, 0, 0, 8'hA7, 0};
        tv[1]  = '{0, 0, 8'h00, 5, 5, 1, 8'h3C, 0, 0, 8'hA7, 8'h3C, 0, 0, 8'hA7, 0};
        tv[2]  = '{0, 0, 8'h00, 9, 5, 0, 8'h00, 1, 9, 8'h00, 8'hA7, 0, 0, 8'h00, 0};
        tv[3]  = '{0, 0, 8'h00, 9, 9, 0, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 1};
        tv[4]  = '{1, 9, 8'h11, 9, 9, 1, 8'h22, 0, 0, 8'h11, 8'h22, 0, 0, 8'h11, 0};
        tv[5]  = '{0, 0, 8'h00, 9, 9, 0, 8'h00, 0, 0, 8'h11, 8'h11, 0, 0, 8'h11, 0};
        tv[6]  = '{1, 4, 8'h6B, 4, 4, 0, 8'h00, 1, 4, 8'h6B, 8'h6B, 0, 0, 8'h6B, 0};
        tv[7]  = '{0, 0, 8'h00, 4, 4, 0, 8'h00, 0, 0, 8'h6B, 8'h6B, 1, 1, 8'h6B, 1};
        tv[8]  = '{1, 3, 8'h55, 3, 4, 0, 8'h00, 0, 0, 8'h55, 8'h6B, 0, 1, 8'h55, 0};
        tv[9]  = '{0, 0, 8'h00, 3, 0, 0, 8'h00, 0, 0, 8'h55, 8'h00, 0, 0, 8'h55, 0};
        tv[10] = '{1, 0, 8'hFF, 0, 3, 0, 8'h00, 1, 0, 8'hFF, 8'h55, 0, 0, 8'h00, 0};
        tv[11] = '{0, 0, 8'h00, 0, 3, 0, 8'h00, 0, 0, 8'hFF, 8'h55, 1, 0, 8'h00, 0};

        idle();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        sweep_count("rst_sweep");

        // back into CLEAR, then reset again on sweep edge 7
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_in_run", {7'd0, i0.ready}, 8'd0);
        for (int e = 1; e <= 6; e++) begin
            rand_in(1'b1);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        sweep_count("rst_mid_sweep");

        for (int i = 0; i < 12; i++) begin
            i0.we = tv[i].we; i0.waddr = tv[i].wa; i0.wdata = tv[i].wd;
            i0.raddrA = tv[i].ra; i0.raddrB = tv[i].rb;
            i0.use_imm = tv[i].ui; i0.imm = tv[i].iv;
            i0.set_pend = tv[i].sp; i0.pend_addr = tv[i].pa;
            i0.clear_req = 1'b0;
            step_pre();
            chk($sformatf("tv%0d_a", i), i0.data_outA, tv[i].ea);
            chk($sformatf("tv%0d_b", i), i0.data_outB, tv[i].eb);
            chk($sformatf("tv%0d_busyA", i), {7'd0, i0.busyA}, {7'd0, tv[i].ba});
            chk($sformatf("tv%0d_busyB", i), {7'd0, i0.busyB}, {7'd0, tv[i].bb});
            chk($sformatf("tv%0d_za", i), iz.data_outA, tv[i].eaz);
            chk($sformatf("tv%0d_zbusyA", i), {7'd0, iz.busyA}, {7'd0, tv[i].baz});
            step_post();
        end

        idle();
        i0.clear_req = 1'b1;
        step();
        i0.clear_req = 1'b0;
        for (int e = 1; e <= DEPTH; e++) begin
            rand_in(1'b0);
            i0.we = 1'b1;
            i0.waddr = 4'd3;
            step();
            chk("clr_sweep", {7'd0, i0.ready}, {7'd0, (e == DEPTH)});
        end
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            i0.raddrA = 4'(a);
            i0.raddrB = 4'(a);
            step_pre();
            chk($sformatf("post_clr_a%0d", a), i0.data_outA, 8'h00);
            chk($sformatf("post_clr_busy%0d", a), {7'd0, i0.busyA | i0.busyB}, 8'd0);
            step_post();
        end

        for (int n = 0; n < 800; n++) begin
            rand_in(1'b1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised successor to the 8-bit, 16-entry processor register file.
- Configurable data width, depth, optional hard-wired zero register and an immediate select on port B.
- Adds write-enable, same-cycle write-to-read bypass, a per-register pending scoreboard for multi-cycle producers, and a multi-cycle clear sweep with a ready flag.
- Sits between decode (read addresses, immediate) and writeback/load unit (write port, pending set).

Parameters:
- W, 8, data path width in bits.
- DEPTH, 16, number of registers; power of two, at least 2.
- AW, $clog2(DEPTH), address width; derived, do not override.
- ZERO_REG, 0, when 1, register 0 always reads 0 and ignores writes and pending sets.

Ports:
- CLK  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write enable.
- waddr  input  AW  write address.
- wdata  input  W  write data.
- raddrA  input  AW  read address, port A.
- raddrB  input  AW  read address, port B.
- use_imm  input  1  1: data_outB = imm; 0: data_outB = register read.
- imm  input  W  immediate value.
- set_pend  input  1  mark pend_addr as awaiting a producer.
- pend_addr  input  AW  scoreboard address.
- clear_req  input  1  request a full clear sweep (RUN state only).
- data_outA  output  W  read data, port A.
- data_outB  output  W  read data or immediate, port B.
- busyA  output  1  port A operand not yet available.
- busyB  output  1  port B operand not yet available; 0 when use_imm=1.
- ready  output  1  1 in RUN; 0 during CLEAR.

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, port named reset.
- State machine has two states, CLEAR and RUN.
- Reset (sampled high at a CLK edge): state=CLEAR, idx=0, ready=0. Reset takes priority over every other input, including mid-sweep; the sweep restarts at idx 0.
- CLEAR, one register per edge: registers[idx]<=0, pend[idx]<=0, idx<=idx+1.
  - On the edge that clears idx=DEPTH-1: state<=RUN, ready<=1.
  - ready rises exactly DEPTH edges after the first edge with reset low.
  - we, set_pend and clear_req are ignored.
  - data_outA, data_outB, busyA and busyB are forced to 0, including any immediate.
- RUN to CLEAR: clear_req=1 at an edge gives state<=CLEAR, idx<=0, ready<=0. No write or pend update is performed on that edge.
- Write (RUN): we=1 gives registers[waddr]<=wdata and pend[waddr]<=0 at the edge. With ZERO_REG=1 and waddr=0, the write is dropped.
- Pending (RUN): set_pend=1 gives pend[pend_addr]<=1.
  - If set_pend and we target the same address in the same cycle, the data is written and pend ends 1 (the new producer wins).
  - With ZERO_REG=1 and pend_addr=0, the set is dropped.
- Reads are combinational, zero latency.
  - Port A = registers[raddrA], with bypass: if we=1, waddr==raddrA and the write is not dropped, data_outA = wdata.
  - Port B is the same, with use_imm=1 overriding to imm.
  - ZERO_REG=1 with raddr=0 gives 0.
- busyX = pend[raddrX], forced to 0 when that port is bypassing the current write.
  - Exception: a simultaneous set_pend to the same address does not make busy high this cycle; it takes effect next cycle.
- Both ports may read the same address; no arbitration is needed.
- Widths: no arithmetic other than idx increment; idx is AW+1 bits or compared before wrap, so it never aliases.

Decomposition:
- Package reg_file_pkg: state enum rf_state_t {RF_CLEAR, RF_RUN}.
- Register array, bypass and scoreboard stay in reg_file_param.
- One natural sub-module, reg_file_clear_seq: owns state, idx and ready; outputs clr_en and clr_idx.

Test Plan (W=8, DEPTH=16 unless stated):
- Reset held 3 cycles then released: ready=0 for 16 edges, then 1; all reads return 0. Re-assert reset at sweep edge 7: ready stays 0 for 16 more edges.
- In RUN, write r5=0xA7 with raddrA=5 in the same cycle: data_outA=0xA7 combinationally. Next cycle with we=0: still 0xA7. Immediate path: raddrB=5, use_imm=1, imm=0x3C gives data_outB=0x3C and busyB=0.
- set_pend r9, next cycle raddrA=9: busyA=1. Write r9=0x11: busyA=0 in the write cycle (bypass) and after.
- set_pend and we to r4 in the same cycle: r4=data, busy=1 next cycle.
- ZERO_REG=1: write r0=0xFF and set_pend r0, then read r0: data_outA=0, busyA=0.
- During RUN, r3=0x55, then pulse clear_req: ready=0 for 16 edges. Writes issued during the sweep are ignored. Afterwards r3 reads 0 and all busy flags are 0.
